// File: rtl/uart_fifo_bridge_pkg.sv
// Shared register-map constants and status-word helpers for the UART FIFO bridge.
package uart_fifo_bridge_pkg;

    typedef enum logic [1:0] {
        UART_RX_STAT = 2'd0,
        UART_RX_DATA = 2'd1,
        UART_TX_STAT = 2'd2,
        UART_TX_DATA = 2'd3
    } uart_offset_e;

    localparam int RX_STAT_NOT_EMPTY_BIT = 0;
    localparam int TX_STAT_NOT_FULL_BIT  = 0;
    localparam int TX_STAT_OVF_BIT       = 1;

    // Builds the RX status word: only the not-empty flag is populated.
    function automatic logic [31:0] rx_status_word(input logic rx_not_empty);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[RX_STAT_NOT_EMPTY_BIT] = rx_not_empty;
        return w;
    endfunction

    // Builds the TX status word from the not-full and sticky overflow flags.
    function automatic logic [31:0] tx_status_word(input logic tx_not_full, input logic tx_ovf);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[TX_STAT_NOT_FULL_BIT] = tx_not_full;
        w[TX_STAT_OVF_BIT]      = tx_ovf;
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Byte-wide synchronous FIFO; pop is ignored when empty and a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests against occupancy and compute next pointers/count.
    always_comb begin
        do_pop_s  = pop & (count_q != {(AW+1){1'b0}});
        do_push_s = push & ((count_q != CNT_FULL) | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == {(AW+1){1'b0}});
    assign count = count_q;

endmodule

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped bridge between the CPU UART window and the UART byte ports,
// buffering each direction in its own FIFO.
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  offset,
    input  logic [7:0]  cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic        wr_s, rd_s;
    logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [AW:0] tx_count_s, rx_count_s;
    logic [7:0]  tx_dout_s, rx_dout_s;
    logic        tx_ovf_q, tx_ovf_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;

    // CPU strobes; a store wins over a load if both are raised.
    always_comb begin
        wr_s      = wr_en & ~stall;
        rd_s      = rd_en & ~stall & ~wr_en;
        tx_push_s = wr_s & (offset == UART_TX_DATA);
        tx_pop_s  = uart_din_ready & ~tx_empty_s;
        rx_push_s = uart_dout_valid & ~rx_full_s;
        rx_pop_s  = rd_s & (offset == UART_RX_DATA);
    end

    sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (cpu_wdata),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (uart_dout),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    // Sticky overflow flag and registered load data.
    always_comb begin
        tx_ovf_d    = tx_ovf_q;
        cpu_rdata_d = cpu_rdata_q;
        if (tx_push_s & tx_full_s & ~tx_pop_s) begin
            tx_ovf_d = 1'b1;
        end else if (rd_s & (offset == UART_TX_STAT)) begin
            tx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q;
        end
        if (rd_s) begin
            case (offset)
                UART_RX_STAT: cpu_rdata_d = rx_status_word(~rx_empty_s);
                UART_RX_DATA: cpu_rdata_d = rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_dout_s};
                UART_TX_STAT: cpu_rdata_d = tx_status_word(~tx_full_s, tx_ovf_q);
                default:      cpu_rdata_d = 32'h0000_0000;
            endcase
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
    end

    // CPU-visible registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_q    <= 1'b0;
            cpu_rdata_q <= 32'h0000_0000;
        end else begin
            tx_ovf_q    <= tx_ovf_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign cpu_rdata       = cpu_rdata_q;
    assign uart_din        = tx_dout_s;
    assign uart_din_valid  = (tx_count_s != {(AW+1){1'b0}});
    assign uart_dout_ready = (rx_count_s != CNT_FULL);

endmodule
